// File: rtl/lynxTypes.sv
// Shared field layout, bus widths and arbiter state encoding for the TCP TX path.
package lynxTypes;

  localparam int META_W       = 32;
  localparam int STAT_W       = 64;
  localparam int DATA_W       = 512;
  localparam int KEEP_W       = 64;

  localparam int META_SID_LSB = 0;
  localparam int META_LEN_LSB = 16;
  localparam int STAT_SID_LSB = 0;
  localparam int STAT_LEN_LSB = 16;
  localparam int FIELD_W      = 16;
  localparam int STAT_ERR_LSB = 62;
  localparam int STAT_ERR_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_META = 2'd1,
    ST_STAT = 2'd2,
    ST_DATA = 2'd3
  } arb_state_t;

  function automatic logic [STAT_ERR_W-1:0] stat_err(input logic [STAT_W-1:0] stat);
    return stat[STAT_ERR_LSB +: STAT_ERR_W];
  endfunction

endpackage

// File: rtl/tcp_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr wins.
module tcp_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  // scan requesters in priority order starting at ptr
  always_comb begin : p_pick
    int   cand;
    logic hit;
    logic found;
    grant = '0;
    idx   = '0;
    cand  = 0;
    hit   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand        = (int'(ptr) + i) % N_REQ;
      hit         = req[cand] & ~found;
      grant[cand] = grant[cand] | hit;
      idx         = hit ? IW'(cand) : idx;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/tcp_tx_arbiter.sv
// Shares one TCP TX meta/status/data path among N_REQ requesters, one transfer at a time.
// Optional STAT watchdog: define TCP_TX_ARB_WATCHDOG_EN.
module tcp_tx_arbiter
  import lynxTypes::*;
#(
  parameter int N_REQ        = 4,
  parameter int STAT_TIMEOUT = 4096
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [N_REQ-1:0]         s_tx_meta_valid,
  output logic [N_REQ-1:0]         s_tx_meta_ready,
  input  logic [N_REQ*META_W-1:0]  s_tx_meta_data,
  output logic                     m_tx_meta_valid,
  input  logic                     m_tx_meta_ready,
  output logic [META_W-1:0]        m_tx_meta_data,
  input  logic                     s_tx_stat_valid,
  output logic                     s_tx_stat_ready,
  input  logic [STAT_W-1:0]        s_tx_stat_data,
  output logic [N_REQ-1:0]         m_tx_stat_valid,
  input  logic [N_REQ-1:0]         m_tx_stat_ready,
  output logic [STAT_W-1:0]        m_tx_stat_data,
  input  logic [N_REQ-1:0]         s_axis_tvalid,
  output logic [N_REQ-1:0]         s_axis_tready,
  input  logic [N_REQ*DATA_W-1:0]  s_axis_tdata,
  input  logic [N_REQ*KEEP_W-1:0]  s_axis_tkeep,
  input  logic [N_REQ-1:0]         s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [KEEP_W-1:0]        m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     timeout_err
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     g_r;
  logic [IW-1:0]     gidx_s;
  logic [IW-1:0]     ptr_nxt_s;
  logic [N_REQ-1:0]  grant_s;
  logic [META_W-1:0] meta_r;
  logic              any_s;
  logic              stat_hs_s;
  logic              wd_exp_s;

  tcp_rr_arb #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req   (s_tx_meta_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (gidx_s)
  );

  assign any_s          = |s_tx_meta_valid;
  assign ptr_nxt_s      = (gidx_s == IW'(N_REQ - 1)) ? IW'(0) : gidx_s + IW'(1);
  assign stat_hs_s      = (state_r == ST_STAT) && s_tx_stat_valid && m_tx_stat_ready[g_r];
  assign m_tx_meta_data = meta_r;

  // state register plus grant-time latches (owner, meta, next pointer)
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      g_r      <= '0;
      meta_r   <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_IDLE && any_s) begin
        g_r      <= gidx_s;
        meta_r   <= s_tx_meta_data[int'(gidx_s)*META_W +: META_W];
        rr_ptr_r <= ptr_nxt_s;
      end
    end
  end

`ifdef TCP_TX_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_r;
  logic        timeout_err_r;

  assign wd_exp_s    = (state_r == ST_STAT) && (wd_cnt_r == 16'(STAT_TIMEOUT - 1)) && !stat_hs_s;
  assign timeout_err = timeout_err_r;

  // STAT dwell counter; it sits at zero outside STAT so each entry starts fresh
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt_r      <= 16'd0;
      timeout_err_r <= 1'b0;
    end else begin
      wd_cnt_r      <= (state_r == ST_STAT) ? wd_cnt_r + 16'd1 : 16'd0;
      timeout_err_r <= wd_exp_s;
    end
  end
`else
  logic unused_wd_s;

  assign wd_exp_s    = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_wd_s = |{1'b0, 32'(STAT_TIMEOUT)};
`endif

  // next state and handshake routing; everything is forced low while reset is held
  always_comb begin
    state_s         = state_r;
    s_tx_meta_ready = '0;
    m_tx_meta_valid = 1'b0;
    s_tx_stat_ready = 1'b0;
    m_tx_stat_valid = '0;
    m_tx_stat_data  = '0;
    s_axis_tready   = '0;
    m_axis_tvalid   = 1'b0;
    m_axis_tdata    = '0;
    m_axis_tkeep    = '0;
    m_axis_tlast    = 1'b0;
    if (aresetn) begin
      case (state_r)
        ST_IDLE: begin
          s_tx_meta_ready = grant_s;
          state_s         = any_s ? ST_META : ST_IDLE;
        end
        ST_META: begin
          m_tx_meta_valid = 1'b1;
          state_s         = m_tx_meta_ready ? ST_STAT : ST_META;
        end
        ST_STAT: begin
          m_tx_stat_valid[g_r] = s_tx_stat_valid;
          m_tx_stat_data       = s_tx_stat_data;
          s_tx_stat_ready      = m_tx_stat_ready[g_r];
          if (stat_hs_s) begin
            // a failed status drops the transfer; the requester retries from scratch
            state_s = (stat_err(s_tx_stat_data) != 2'b00) ? ST_IDLE : ST_DATA;
          end else begin
            state_s = wd_exp_s ? ST_IDLE : ST_STAT;
          end
        end
        ST_DATA: begin
          s_axis_tready[g_r] = m_axis_tready;
          m_axis_tvalid      = s_axis_tvalid[g_r];
          m_axis_tdata       = s_axis_tdata[int'(g_r)*DATA_W +: DATA_W];
          m_axis_tkeep       = s_axis_tkeep[int'(g_r)*KEEP_W +: KEEP_W];
          m_axis_tlast       = s_axis_tlast[g_r];
          state_s            = (s_axis_tvalid[g_r] && m_axis_tready && s_axis_tlast[g_r]) ? ST_IDLE : ST_DATA;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = ST_IDLE;
    end
  end

endmodule
